// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit.
//   - funct3 encodings of the RISC-V load/store widths
//   - FSM state encoding (lsu_state_t)
//   - helpers: last byte index of an access, and width/alignment legality
package riscv_lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_XFER = 2'd1,
    LSU_LAST = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  // Index of the final byte of an access: N-1 for N = 1/2/4.
  function automatic logic [1:0] lsu_last_idx(input logic [2:0] funct3);
    case (funct3)
      LSU_W:         lsu_last_idx = 2'd3;
      LSU_H, LSU_HU: lsu_last_idx = 2'd1;
      default:       lsu_last_idx = 2'd0;
    endcase
  endfunction

  // Illegal width, misalignment, or unsigned-store encoding.
  // The address-range check depends on MEM_AW and is done in the top.
  function automatic logic lsu_bad_op(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    case (funct3)
      LSU_B:   lsu_bad_op = 1'b0;
      LSU_BU:  lsu_bad_op = we;
      LSU_H:   lsu_bad_op = addr_lo[0];
      LSU_HU:  lsu_bad_op = we | addr_lo[0];
      LSU_W:   lsu_bad_op = (addr_lo != 2'b00);
      default: lsu_bad_op = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data extension (combinational).
// Ports:
//   raw    - assembled little-endian load bytes (unused upper bytes are 0)
//   funct3 - access width/signedness
//   result - sign-extended (b, h), zero-extended (bu, hu) or unchanged (w)
module lsu_extend
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (funct3)
      LSU_B:   result = {{24{raw[7]}}, raw[7:0]};
      LSU_H:   result = {{16{raw[15]}}, raw[15:0]};
      LSU_BU:  result = {24'h000000, raw[7:0]};
      LSU_HU:  result = {16'h0000, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit in front of a byte-wide synchronous memory.
// Ports:
//   clk, reset            - clock; synchronous active-low reset
//   req_valid/req_ready   - access request handshake; req_we, req_funct3,
//                           req_addr, req_wdata describe the access
//   rsp_valid/rsp_rdata/rsp_err - one-cycle completion pulse with load data
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata - byte memory port; read
//                           data arrives the cycle after a read issue
//   dbg_state             - current FSM state for observation
//
// Handshake: an access is taken on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE, so the request fields
// are latched once and ignored until the unit returns to IDLE. There is no
// backpressure on the response: rsp_valid is a single-cycle pulse.
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        dbg_state
);

  lsu_state_t        state, state_n;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q, data_q, ext;
  logic [1:0]        cnt, cap_idx;
  logic              hs, req_err, xfer_done;

  assign hs        = req_valid & req_ready;
  assign req_err   = lsu_bad_op(req_we, req_funct3, req_addr[1:0]) |
                     (req_addr[31:MEM_AW] != '0);
  // Read data lags its issue by one cycle, so the byte landing now belongs
  // to the previous count. In LAST the count has already wrapped past the
  // final byte, so the same expression selects it.
  assign cap_idx   = cnt - 2'd1;
  assign xfer_done = (cnt == lsu_last_idx(f3_q));
  assign dbg_state = state;

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    case (state)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (hs) state_n = req_err ? LSU_RESP : LSU_XFER;
      end
      LSU_XFER: if (xfer_done) state_n = we_q ? LSU_RESP : LSU_LAST;
      LSU_LAST: state_n = LSU_RESP;
      LSU_RESP: state_n = LSU_IDLE;
      default:  state_n = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= LSU_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
      cnt     <= 2'd0;
    end else begin
      state <= state_n;
      case (state)
        LSU_IDLE: if (hs) begin
          we_q    <= req_we;
          err_q   <= req_err;
          f3_q    <= req_funct3;
          addr_q  <= req_addr[MEM_AW-1:0];
          wdata_q <= req_wdata;
          data_q  <= 32'h0;
          cnt     <= 2'd0;
        end
        LSU_XFER: begin
          cnt <= cnt + 2'd1;
          if (!we_q && cnt != 2'd0) data_q[{cap_idx, 3'b000} +: 8] <= mem_rdata;
        end
        LSU_LAST: data_q[{cap_idx, 3'b000} +: 8] <= mem_rdata;
        default: ;
      endcase
    end
  end

  lsu_extend u_extend (
    .raw    (data_q),
    .funct3 (f3_q),
    .result (ext)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    if (state == LSU_XFER) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q + MEM_AW'(cnt);
      mem_wdata = wdata_q[{cnt, 3'b000} +: 8];
    end
    if (state == LSU_RESP) begin
      rsp_valid = 1'b1;
      rsp_err   = err_q;
      if (!err_q && !we_q) rsp_rdata = ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte memory model and a
// response scoreboard (expected err, rdata and completion cycle).
module tb_load_store_unit;
  import riscv_lsu_pkg::*;

  localparam int MEM_AW = 5;
  localparam int W = 65;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic [1:0]        dbg_state;

  load_store_unit #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- byte memory model ----------------
  logic [7:0] mem [32];
  int wr_cnt = 0;
  int en_cnt = 0;
  always @(posedge clk) begin
    if (mem_en) begin
      en_cnt = en_cnt + 1;
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_cnt = wr_cnt + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=rsp_valid expected=none (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e[64]));
        chk("rsp_rdata", rsp_rdata, e[63:32]);
        chk("rsp_cycle", 32'(cyc), e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of cycle 1 after the handshake.
  // hs is the index of the handshake edge; response expected in cycle lat.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic eerr, input logic [31:0] erd,
                       input int lat, input bit keep, input bit push, output int hs);
    int n = 0;
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual=req_ready=0 expected=1");
      req_valid = 1'b0;
      hs = -1;
      return;
    end
    hs = cyc + 1;
    if (push) exp_q.push_back({eerr, erd, 32'(hs + lat - 1)});
    @(negedge clk);
    if (!keep) begin
      // Scrambled fields must not affect the access in flight.
      req_valid = 1'b0;
      req_we = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr = $urandom;
      req_wdata = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs, hs1, hs2, w0, e0;
    for (int i = 0; i < 32; i++) mem[i[4:0]] = 8'h00;
    mem[5] = 8'h80;
    mem[6] = 8'h07;
    mem[12] = 8'h11; mem[13] = 8'h22; mem[14] = 8'h33; mem[15] = 8'h44;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(LSU_IDLE));
    reset = 1'b1;
    @(negedge clk);

    // sb: single write, response in cycle 2
    w0 = wr_cnt;
    issue(1'b1, LSU_B, 32'd4, 32'h1234560F, 1'b0, 32'h0, 2, 1'b0, 1'b1, hs);
    drain();
    chk("sb_mem4", 32'(mem[4]), 32'h0F);
    chk("sb_mem5", 32'(mem[5]), 32'h80);
    chk("sb_writes", 32'(wr_cnt - w0), 32'd1);

    // byte loads, response in cycle 3
    issue(1'b0, LSU_B, 32'd5, 32'h0, 1'b0, 32'hFFFFFF80, 3, 1'b0, 1'b1, hs);
    drain();
    issue(1'b0, LSU_BU, 32'd5, 32'h0, 1'b0, 32'h00000080, 3, 1'b0, 1'b1, hs);
    drain();
    issue(1'b0, LSU_B, 32'd6, 32'h0, 1'b0, 32'h00000007, 3, 1'b0, 1'b1, hs);
    drain();

    // sw then lw
    w0 = wr_cnt;
    issue(1'b1, LSU_W, 32'd8, 32'hDEADBEEF, 1'b0, 32'h0, 5, 1'b0, 1'b1, hs);
    drain();
    chk("sw_mem8", 32'(mem[8]), 32'hEF);
    chk("sw_mem9", 32'(mem[9]), 32'hBE);
    chk("sw_mem10", 32'(mem[10]), 32'hAD);
    chk("sw_mem11", 32'(mem[11]), 32'hDE);
    chk("sw_writes", 32'(wr_cnt - w0), 32'd4);
    issue(1'b0, LSU_W, 32'd8, 32'h0, 1'b0, 32'hDEADBEEF, 6, 1'b0, 1'b1, hs);
    drain();

    // halfword loads
    issue(1'b0, LSU_H, 32'd8, 32'h0, 1'b0, 32'hFFFFBEEF, 4, 1'b0, 1'b1, hs);
    drain();
    issue(1'b0, LSU_HU, 32'd10, 32'h0, 1'b0, 32'h0000DEAD, 4, 1'b0, 1'b1, hs);
    drain();

    // errors: no memory access, response in cycle 1
    e0 = en_cnt;
    issue(1'b0, LSU_H, 32'd3, 32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b1, hs);
    drain();
    issue(1'b1, LSU_W, 32'h40, 32'h01020304, 1'b1, 32'h0, 1, 1'b0, 1'b1, hs);
    drain();
    issue(1'b0, 3'b011, 32'd0, 32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b1, hs);
    drain();
    issue(1'b1, LSU_BU, 32'd1, 32'h55, 1'b1, 32'h0, 1, 1'b0, 1'b1, hs);
    drain();
    issue(1'b0, LSU_W, 32'd2, 32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b1, hs);
    drain();
    chk("err_no_mem_en", 32'(en_cnt - e0), 32'd0);
    chk("err_mem1_kept", 32'(mem[1]), 32'h00);

    // back-to-back with req_valid held high
    issue(1'b0, LSU_BU, 32'd5, 32'h0, 1'b0, 32'h00000080, 3, 1'b1, 1'b1, hs1);
    issue(1'b0, LSU_B, 32'd6, 32'h0, 1'b0, 32'h00000007, 3, 1'b0, 1'b1, hs2);
    chk("b2b_accept_edge", 32'(hs2), 32'(hs1 + 3 + 1));
    drain();

    // reset during a store: only the first byte lands
    w0 = wr_cnt;
    issue(1'b1, LSU_W, 32'd12, 32'hAABBCCDD, 1'b0, 32'h0, 5, 1'b0, 1'b0, hs);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("abort_mem12", 32'(mem[12]), 32'hDD);
    chk("abort_mem13", 32'(mem[13]), 32'h22);
    chk("abort_mem14", 32'(mem[14]), 32'h33);
    chk("abort_mem15", 32'(mem[15]), 32'h44);
    chk("abort_writes", 32'(wr_cnt - w0), 32'd1);

    // unit still works after the abort
    issue(1'b0, LSU_W, 32'd12, 32'h0, 1'b0, 32'h443322DD, 6, 1'b0, 1'b1, hs);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
